bitwise_lu_pipe: RTL and testbench
==================================

// Module: bitwise_lu_pipe
// PURPOSE
//  Parametrised, pipelined successor to the fixed 16-bit bitwise gate arrays: one block, WIDTH-wide, op-selectable.
//  Computes AND/OR/XOR/NAND/NOR/XNOR/NOT/PASS on two operand vectors, plus zero/negative flags.
//  Sits between operand sources (register file / test harness) and consumers (ALU, OSD debug view).
//  Two-stage valid/ready pipeline with full backpressure.
// PARAMETERS
//  WIDTH   16  operand/result width in bits (>=2)
//  OPW     3   op-select width (fixed by package; do not override)
// PORTS
//  clk_sys    in   1      system clock; all logic on rising edge
//  reset_n    in   1      asynchronous, active-low reset
//  in_valid   in   1      operand beat present
//  in_ready   out  1      block accepts beat this cycle
//  in_a       in   WIDTH  operand a
//  in_b       in   WIDTH  operand b
//  in_op      in   OPW    operation select (see BEHAVIOUR)
//  out_valid  out  1      result beat present
//  out_ready  in   1      consumer accepts result this cycle
//  out_data   out  WIDTH  result
//  out_zr     out  1      out_data == 0 (feature-gated)
//  out_ng     out  1      out_data[WIDTH-1] (feature-gated)
// BEHAVIOUR
//  - Reset (reset_n low, async assert, sync-released by clk_sys domain): s1/s2 valid=0, out_valid=0, out_data=0,
//    out_zr=0, out_ng=0; in_ready=1 on first cycle after release. Reset mid-flight discards all beats.
//  - Op codes: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT a (b ignored), 7 PASS a.
//  - Stage 1 registers op result (bitwise, WIDTH bits, no carry/width growth). Stage 2 registers result
//    and, when flags enabled, out_zr = ~|result, out_ng = result[WIDTH-1].
//  - Transfer on valid&&ready at each interface. Latency: accepted beat appears at out_valid exactly 2
//    cycles later if never stalled. Throughput 1 beat/cycle when out_ready held high.
//  - Ready chain: s2_ready = !s2_valid || out_ready; in_ready = !s1_valid || s2_ready (combinational,
//    no skid buffer). Max 2 beats in flight.
//  - Full: s1 and s2 valid, out_ready=0 -> in_ready=0; all registers hold; out_data stable while stalled.
//  - Simultaneous: out_ready=1 with pipe full and in_valid=1 -> s2 takes s1, s1 takes new beat, same cycle.
//  - Empty: out_valid=0; out_data holds last value (not cleared); flags hold.
//  - in_valid=0 while in_ready=1 -> bubble propagates; no beat created.
//  - Illegal states: none; all 8 op codes defined.
// CONFIGURATION
//  Macro BITWISE_LU_FLAGS_EN:
//   defined   -> out_zr/out_ng computed in stage 2 from registered result, valid with out_valid.
//   undefined -> flag logic not built; out_zr and out_ng tied 0. Datapath/latency unchanged.
// STRUCTURE
//  - bitwise_lu_pkg: op-code localparams (LU_AND..LU_PASS), OPW=3.
//  - Sub-module bitwise_lu_stage: generic WIDTH-param valid/ready register slice
//    (data+valid regs, ready = !valid || next_ready), instantiated twice; op decode and flag logic
//    live in top level between slices.
// TESTING
//  1 Reset: hold reset_n=0 mid-stream with 2 beats in flight -> out_valid=0, out_data=0, in_ready=1 after release.
//  2 Ops, WIDTH=16: a=16'hF0F0,b=16'hFF00, ops 0..7 back-to-back, out_ready=1 -> F000,FFF0,0FF0,0FFF,000F,F00F,0F0F,F0F0
//    on consecutive cycles starting 2 cycles after first accept.
//  3 Flags (BITWISE_LU_FLAGS_EN): XOR a=b=16'h1234 -> out_data=0,out_zr=1,out_ng=0; OR a=16'h8000,b=0 -> zr=0,ng=1.
//    Without macro: same stimuli -> zr=ng=0.
//  4 Backpressure: stream 4 beats, out_ready=0 for 5 cycles -> in_ready drops after 2 accepts, out_data stable,
//    all 4 results delivered in order after out_ready=1, none lost/duplicated.
//  5 Simultaneous: pipe full, assert out_ready and in_valid same cycle -> one beat out, one in, count stays 2.
//  6 WIDTH=8 and WIDTH=32 builds: random ops/operands vs reference model, 1000 beats, random ready/valid.

Source files
------------

// File: rtl/bitwise_lu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// bitwise_lu_pkg : op-code encoding shared by the bitwise logic-unit pipeline
// Revision: 1.0
// ----------------------------------------------------------------------------
package bitwise_lu_pkg;

  localparam int OPW = 3;

  typedef logic [OPW-1:0] lu_op_t;

  localparam lu_op_t LU_AND  = 3'd0;
  localparam lu_op_t LU_OR   = 3'd1;
  localparam lu_op_t LU_XOR  = 3'd2;
  localparam lu_op_t LU_NAND = 3'd3;
  localparam lu_op_t LU_NOR  = 3'd4;
  localparam lu_op_t LU_XNOR = 3'd5;
  localparam lu_op_t LU_NOT  = 3'd6;
  localparam lu_op_t LU_PASS = 3'd7;

endpackage : bitwise_lu_pkg
`default_nettype wire

// File: rtl/bitwise_lu_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// bitwise_lu_stage : one valid/ready register slice, ready = !valid || next_ready
// Revision: 1.0
// ----------------------------------------------------------------------------
module bitwise_lu_stage
  import bitwise_lu_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk_sys,
  input  logic         reset_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  assign o_ready = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  // Data only loads on a real beat, so an emptied slice keeps its last value.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

endmodule : bitwise_lu_stage
`default_nettype wire

// File: rtl/bitwise_lu_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// bitwise_lu_pipe : two-stage WIDTH-wide bitwise logic unit with valid/ready.
// Optional zero/negative flags built when BITWISE_LU_FLAGS_EN is defined.
// Revision: 1.0
// ----------------------------------------------------------------------------
module bitwise_lu_pipe
  import bitwise_lu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OPW-1:0]   in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zr,
  output logic             out_ng
);

`ifdef BITWISE_LU_FLAGS_EN
  localparam int S2W = WIDTH + 2;
`else
  localparam int S2W = WIDTH;
`endif

  logic [WIDTH-1:0] w_result;
  logic             w_s1_valid;
  logic [WIDTH-1:0] w_s1_data;
  logic             w_s2_ready;
  logic [S2W-1:0]   w_s2_din;
  logic [S2W-1:0]   w_s2_q;

  always_comb begin
    w_result = '0;
    case (in_op)
      LU_AND:  w_result = in_a & in_b;
      LU_OR:   w_result = in_a | in_b;
      LU_XOR:  w_result = in_a ^ in_b;
      LU_NAND: w_result = ~(in_a & in_b);
      LU_NOR:  w_result = ~(in_a | in_b);
      LU_XNOR: w_result = ~(in_a ^ in_b);
      LU_NOT:  w_result = ~in_a;
      default: w_result = in_a;
    endcase
  end

  bitwise_lu_stage #(
    .W (WIDTH)
  ) u_stage1 (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_data  (w_result),
    .o_valid (w_s1_valid),
    .i_ready (w_s2_ready),
    .o_data  (w_s1_data)
  );

  // Flags travel alongside the result so they stay aligned with out_valid.
`ifdef BITWISE_LU_FLAGS_EN
  assign w_s2_din = {~|w_s1_data, w_s1_data[WIDTH-1], w_s1_data};
  assign out_zr   = w_s2_q[WIDTH+1];
  assign out_ng   = w_s2_q[WIDTH];
`else
  assign w_s2_din = w_s1_data;
  assign out_zr   = 1'b0;
  assign out_ng   = 1'b0;
`endif

  bitwise_lu_stage #(
    .W (S2W)
  ) u_stage2 (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .i_valid (w_s1_valid),
    .o_ready (w_s2_ready),
    .i_data  (w_s2_din),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (w_s2_q)
  );

  assign out_data = w_s2_q[WIDTH-1:0];

endmodule : bitwise_lu_pipe
`default_nettype wire

// File: tb/tb_bitwise_lu_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_bitwise_lu_pipe : directed and random checks against a queue reference model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_bitwise_lu_pipe;
  import bitwise_lu_pkg::*;

  localparam int WIDTH = 16;
`ifdef BITWISE_LU_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic             clk_sys = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic [OPW-1:0]   in_op = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_zr;
  logic             out_ng;

  always #5 clk_sys = ~clk_sys;

  bitwise_lu_pipe #(.WIDTH(WIDTH)) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zr    (out_zr),
    .out_ng    (out_ng)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [WIDTH-1:0] exp_q[$];
  int               exp_c[$];
  logic [WIDTH-1:0] dlv_data[$];
  logic             dlv_zr[$];
  logic             dlv_ng[$];
  int               dlv_cyc[$];
  int               acc_log[$];
  bit               prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_op(input int op, input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    case (op)
      0: return a & b;
      1: return a | b;
      2: return a ^ b;
      3: return ~(a & b);
      4: return ~(a | b);
      5: return ~(a ^ b);
      6: return ~a;
      default: return a;
    endcase
  endfunction

  function automatic logic ref_zr(input logic [WIDTH-1:0] d);
    return FL && (d == '0);
  endfunction

  function automatic logic ref_ng(input logic [WIDTH-1:0] d);
    return FL && d[WIDTH-1];
  endfunction

  // One clock: inputs already driven, sample at negedge, update model, return at posedge+1.
  task automatic step();
    bit               acc;
    bit               dlv;
    bit               exp_valid;
    logic [WIDTH-1:0] hd;
    @(negedge clk_sys);
    acc = in_valid && in_ready;
    dlv = out_valid && out_ready;
    exp_valid = (exp_q.size() > 0) && (exp_c[0] + 2 <= cyc);
    check_eq("in_ready", in_ready, (exp_q.size() < 2) || out_ready);
    check_eq("out_valid", out_valid, exp_valid);
    if (out_valid && exp_q.size() > 0) begin
      hd = exp_q[0];
      check_eq("out_data", out_data, hd);
      check_eq("out_zr", out_zr, ref_zr(hd));
      check_eq("out_ng", out_ng, ref_ng(hd));
    end
    if (prev_stall) check_eq("stall_hold", out_data, prev_data);
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    if (dlv) begin
      dlv_data.push_back(out_data);
      dlv_zr.push_back(out_zr);
      dlv_ng.push_back(out_ng);
      dlv_cyc.push_back(cyc);
      if (exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        void'(exp_c.pop_front());
      end
    end
    if (acc) begin
      exp_q.push_back(ref_op(int'(in_op), in_a, in_b));
      exp_c.push_back(cyc);
      acc_log.push_back(cyc);
    end
    cyc++;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic clear_logs();
    dlv_data.delete();
    dlv_zr.delete();
    dlv_ng.delete();
    dlv_cyc.delete();
    acc_log.delete();
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
    check_eq("drain_empty", exp_q.size(), 0);
  endtask

  task automatic drive(input int op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    in_valid = 1'b1;
    in_op    = OPW'(op);
    in_a     = a;
    in_b     = b;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] tbl [8];
    logic [WIDTH-1:0] bp_a [4];
    logic [WIDTH-1:0] bp_b [4];
    int               bp_op [4];
    int               idx;
    int               na;
    int               nd;
    bit               took;

    // Reset state and first cycle after release
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    @(posedge clk_sys);
    #1 reset_n = 1'b1;
    @(negedge clk_sys);
    check_eq("rel_in_ready", in_ready, 1);
    check_eq("rel_out_valid", out_valid, 0);
    check_eq("rel_out_data", out_data, 0);
    check_eq("rel_zr", out_zr, 0);
    check_eq("rel_ng", out_ng, 0);
    @(posedge clk_sys);
    #1;

    // Reset with two beats in flight discards them
    out_ready = 1'b0;
    drive(1, 16'h1357, 16'h8001); step();
    drive(7, 16'hBEEF, 16'h0000); step();
    in_valid = 1'b0;
    step();
    #2 reset_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_out_data", out_data, 0);
    exp_q.delete();
    exp_c.delete();
    prev_stall = 1'b0;
    @(posedge clk_sys);
    @(posedge clk_sys);
    #1 reset_n = 1'b1;
    @(negedge clk_sys);
    check_eq("midrst_in_ready", in_ready, 1);
    check_eq("midrst_valid_after", out_valid, 0);
    check_eq("midrst_data_after", out_data, 0);
    @(posedge clk_sys);
    #1;

    // All eight ops back to back, fixed operands
    tbl = '{16'hF000, 16'hFFF0, 16'h0FF0, 16'h0FFF, 16'h000F, 16'hF00F, 16'h0F0F, 16'hF0F0};
    clear_logs();
    out_ready = 1'b1;
    for (int op = 0; op < 8; op++) begin
      drive(op, 16'hF0F0, 16'hFF00);
      step();
    end
    drain();
    check_eq("ops_count", dlv_data.size(), 8);
    for (int i = 0; i < 8 && i < dlv_data.size() && acc_log.size() > 0; i++) begin
      check_eq($sformatf("op%0d_data", i), dlv_data[i], tbl[i]);
      check_eq($sformatf("op%0d_cycle", i), dlv_cyc[i], acc_log[0] + 2 + i);
    end

    // Flags
    clear_logs();
    drive(2, 16'h1234, 16'h1234); step();
    drive(1, 16'h8000, 16'h0000); step();
    drain();
    check_eq("flag_count", dlv_data.size(), 2);
    if (dlv_data.size() == 2) begin
      check_eq("xor_data", dlv_data[0], 16'h0000);
      check_eq("xor_zr", dlv_zr[0], FL);
      check_eq("xor_ng", dlv_ng[0], 0);
      check_eq("or_data", dlv_data[1], 16'h8000);
      check_eq("or_zr", dlv_zr[1], 0);
      check_eq("or_ng", dlv_ng[1], FL);
    end

    // Backpressure: four beats against a stalled consumer
    clear_logs();
    bp_op = '{0, 3, 6, 2};
    for (int i = 0; i < 4; i++) begin
      bp_a[i] = WIDTH'($urandom);
      bp_b[i] = WIDTH'($urandom);
    end
    out_ready = 1'b0;
    idx = 0;
    for (int i = 0; i < 5; i++) begin
      if (idx < 4) drive(bp_op[idx], bp_a[idx], bp_b[idx]);
      na = acc_log.size();
      step();
      if (acc_log.size() > na) idx++;
    end
    check_eq("bp_accepts", idx, 2);
    check_eq("bp_no_output", dlv_data.size(), 0);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && idx < 4; i++) begin
      drive(bp_op[idx], bp_a[idx], bp_b[idx]);
      na = acc_log.size();
      step();
      if (acc_log.size() > na) idx++;
    end
    check_eq("bp_all_accepted", idx, 4);
    drain();
    check_eq("bp_delivered", dlv_data.size(), 4);
    for (int i = 0; i < 4 && i < dlv_data.size(); i++)
      check_eq($sformatf("bp%0d_data", i), dlv_data[i], ref_op(bp_op[i], bp_a[i], bp_b[i]));

    // Simultaneous in/out on a full pipe
    clear_logs();
    out_ready = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() < 2; i++) begin
      drive(int'($urandom_range(0, 7)), WIDTH'($urandom), WIDTH'($urandom));
      step();
    end
    check_eq("sim_full", exp_q.size(), 2);
    drive(5, 16'hA5A5, 16'h0FF0);
    out_ready = 1'b1;
    na = acc_log.size();
    nd = dlv_data.size();
    step();
    check_eq("sim_one_in", acc_log.size() - na, 1);
    check_eq("sim_one_out", dlv_data.size() - nd, 1);
    check_eq("sim_inflight", exp_q.size(), 2);
    drain();

    // Random valid/ready traffic
    clear_logs();
    took = 1'b0;
    for (int i = 0; i < 20000 && acc_log.size() < 1000; i++) begin
      if (!in_valid || took) begin
        in_valid = ($urandom % 4) != 0;
        in_a     = WIDTH'($urandom);
        in_b     = WIDTH'($urandom);
        in_op    = OPW'($urandom_range(0, 7));
      end
      out_ready = ($urandom % 10) < 7;
      na = acc_log.size();
      step();
      took = acc_log.size() > na;
    end
    check_eq("rnd_accepted", acc_log.size(), 1000);
    drain();
    check_eq("rnd_delivered", dlv_data.size(), acc_log.size());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_bitwise_lu_pipe
`default_nettype wire
